bpred_btb: RTL and testbench
============================

# bpred_btb

Branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the IF stage. Each cycle it looks up the PC that IF presents to instruction memory and returns a registered taken/target prediction one cycle later, which IF uses as its next-PC choice. Resolved branches from the ID stage (the same point that raises Request_Alt_PC/Alt_PC) train the table through a single-write update port.

## Interface
- ENTRIES, 64: number of BTB entries; power of two, at least 4; IDX = log2(ENTRIES).
- TAG_BITS, 24: stored tag width; must be at most 30-IDX; tag = Fetch_PC[IDX+2+TAG_BITS-1 : IDX+2].

- CLK  in  1  clock, rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- Fetch_PC  in  32  PC IF sends to instruction memory this cycle.
- STALL  in  1  ID freeze request; when 1, hold the lookup.
- Pred_Valid  out  1  Pred_* fields are meaningful.
- Pred_PC  out  32  Fetch_PC the prediction belongs to.
- Pred_Taken  out  1  BTB hit and counter[1]==1.
- Pred_Target  out  32  stored target; 0 on a miss.
- Update_Valid  in  1  a branch resolved this cycle.
- Update_PC  in  32  PC of the resolved branch.
- Update_Taken  in  1  actual direction.
- Update_Target  in  32  actual target; used only when taken.

## Operation
- Entry contents: valid, tag[TAG_BITS], target[32], ctr[2]. Index = PC[IDX+1:2]; PC[1:0] are ignored.
- Lookup happens at each rising edge with STALL=0. At that edge: Pred_PC<=Fetch_PC and Pred_Valid<=1. On a hit (valid and tag match), Pred_Target<=target and Pred_Taken<=ctr[1]. On a miss, Pred_Taken<=0 and Pred_Target<=0.
- Lookup with STALL=1: all Pred_* outputs hold their values.
- Update happens at each rising edge with Update_Valid=1, independent of STALL:
  - Hit: ctr saturates up when taken and down when not taken (range 00..11). target<=Update_Target only when taken.
  - Miss and taken: allocate the entry, overwriting any previous occupant. Set valid=1, tag, target, ctr=10.
  - Miss and not taken: no write.
- Only one update per cycle. An update and a lookup to the same index in the same cycle: the lookup returns the pre-update contents (read-before-write).
- Counter arithmetic never wraps: 11 stays 11 on taken, and 00 stays 00 on not-taken.

## Timing
- Lookup latency is 1 cycle: Fetch_PC sampled at edge t yields a prediction during cycle t+1.
- Update latency is 1 cycle: an entry written at edge t is visible to a lookup sampled at edge t+1.
- Reset (RESET=0, any time, including mid-update) takes effect asynchronously:
  - all valid bits cleared and all ctr set to 01;
  - Pred_Valid=0, Pred_PC=0, Pred_Taken=0, Pred_Target=0.
- The first lookup after RESET rises occurs at the first edge with STALL=0.
- An update presented while RESET=0 is discarded.

## Configuration
- BPRED_GSHARE_EN defined:
  - Counters move to a separate pattern history table of ENTRIES 2-bit entries, indexed by PC[IDX+1:2] XOR GHR.
  - GHR is an IDX-bit global history register, reset to 0.
  - Pred_Taken = BTB hit AND PHT counter[1].
  - Updates index the PHT with the GHR value current at the update edge, then shift Update_Taken into GHR bit 0.
  - PHT counters train on every update, hit or miss; BTB allocation rules are unchanged.
- BPRED_GSHARE_EN undefined: counters live in the BTB entry as described above; no GHR exists.

## Test plan
- Reset then lookup 0x00400020 -> Pred_Valid=1, Pred_Taken=0, Pred_Target=0 one cycle after sampling.
- Update PC=0x00400020, taken, target=0x00400100; next-cycle lookup of 0x00400020 -> Pred_Taken=1, Pred_Target=0x00400100 (ctr=10).
- Same PC trained not-taken twice -> ctr 10->01->00; lookup gives Pred_Taken=0, Pred_Target=0x00400100; a third not-taken keeps 00.
- Alias: 0x00400120 (same index, different tag) looked up after the test above -> miss. A taken update to 0x00400120 replaces the entry, after which 0x00400020 misses.
- Same-cycle update and lookup of 0x00400040 -> miss that cycle, hit on the following lookup. With STALL=1 held for 3 cycles, Pred_* stays frozen while the update still commits.
- Assert RESET low mid-operation -> outputs 0 immediately and all entries miss afterwards. With BPRED_GSHARE_EN: alternating T/N/T/N on one PC reaches steady-state correct predictions within 8 updates.

Source files
------------

// File: rtl/bpred_btb.sv
// Branch target buffer with 2-bit saturating direction counters, one-cycle registered prediction.
// Optional BPRED_GSHARE_EN moves the counters into a GHR-xor-indexed pattern history table.
module bpred_btb #(
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 24
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Fetch_PC,
  input  logic        STALL,
  output logic        Pred_Valid,
  output logic [31:0] Pred_PC,
  output logic        Pred_Taken,
  output logic [31:0] Pred_Target,
  input  logic        Update_Valid,
  input  logic [31:0] Update_PC,
  input  logic        Update_Taken,
  input  logic [31:0] Update_Target
);

  localparam int IDX = $clog2(ENTRIES);

  function automatic logic [IDX-1:0] pc_idx(input logic [31:0] pc);
    return pc[IDX+1:2];
  endfunction

  function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] pc);
    return pc[IDX+2+TAG_BITS-1:IDX+2];
  endfunction

  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    else       return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  logic [ENTRIES-1:0]  ent_vld;
  logic [TAG_BITS-1:0] ent_tag [ENTRIES];
  logic [31:0]         ent_tgt [ENTRIES];

  logic [IDX-1:0] lk_idx_p0, upd_idx_p0;
  logic           lk_hit_p0, upd_hit_p0;
  logic [1:0]     lk_ctr_p0;
  logic           unused_pc_bits;

  assign lk_idx_p0      = pc_idx(Fetch_PC);
  assign upd_idx_p0     = pc_idx(Update_PC);
  assign lk_hit_p0      = ent_vld[lk_idx_p0] && (ent_tag[lk_idx_p0] == pc_tag(Fetch_PC));
  assign upd_hit_p0     = ent_vld[upd_idx_p0] && (ent_tag[upd_idx_p0] == pc_tag(Update_PC));
  assign unused_pc_bits = ^{Fetch_PC[1:0], Update_PC[1:0]};

`ifdef BPRED_GSHARE_EN
  logic [IDX-1:0] ghr;
  logic [1:0]     pht [ENTRIES];
  logic [IDX-1:0] pht_upd_idx_p0;

  assign lk_ctr_p0      = pht[lk_idx_p0 ^ ghr];
  assign pht_upd_idx_p0 = upd_idx_p0 ^ ghr;

  // PHT trains on every resolved branch; the BTB only allocates on a taken miss
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ent_vld <= '0;
      ghr     <= '0;
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
    end else if (Update_Valid) begin
      pht[pht_upd_idx_p0] <= sat_ctr(pht[pht_upd_idx_p0], Update_Taken);
      ghr                 <= {ghr[IDX-2:0], Update_Taken};
      if (!upd_hit_p0 && Update_Taken) ent_vld[upd_idx_p0] <= 1'b1;
    end
  end
`else
  logic [1:0] ent_ctr [ENTRIES];

  assign lk_ctr_p0 = ent_ctr[lk_idx_p0];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ent_vld <= '0;
      for (int i = 0; i < ENTRIES; i++) ent_ctr[i] <= 2'b01;
    end else if (Update_Valid) begin
      if (upd_hit_p0) begin
        ent_ctr[upd_idx_p0] <= sat_ctr(ent_ctr[upd_idx_p0], Update_Taken);
      end else if (Update_Taken) begin
        ent_vld[upd_idx_p0] <= 1'b1;
        ent_ctr[upd_idx_p0] <= 2'b10;
      end
    end
  end
`endif

  // Any taken update writes tag/target: a hit rewrites the same tag, a miss allocates
  always_ff @(posedge CLK) begin
    if (RESET && Update_Valid && Update_Taken) begin
      ent_tag[upd_idx_p0] <= pc_tag(Update_PC);
      ent_tgt[upd_idx_p0] <= Update_Target;
    end
  end

  // ---- stage p0 -> p1: registered prediction, reads pre-update contents ----
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Pred_Valid  <= 1'b0;
      Pred_PC     <= '0;
      Pred_Taken  <= 1'b0;
      Pred_Target <= '0;
    end else if (!STALL) begin
      Pred_Valid  <= 1'b1;
      Pred_PC     <= Fetch_PC;
      Pred_Taken  <= lk_hit_p0 && lk_ctr_p0[1];
      Pred_Target <= lk_hit_p0 ? ent_tgt[lk_idx_p0] : 32'h0;
    end
  end

endmodule

// File: tb/tb_bpred_btb.sv
// Directed self-checking bench for bpred_btb (default build, counters in the BTB entries).
module tb_bpred_btb;

  localparam logic [31:0] P  = 32'h0040_0020;
  localparam logic [31:0] A  = 32'h0040_0120;
  localparam logic [31:0] Q  = 32'h0040_0040;
  localparam logic [31:0] R  = 32'h0040_0080;
  localparam logic [31:0] T1 = 32'h0040_0100;
  localparam logic [31:0] T2 = 32'h0040_0200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bpred_btb #(.ENTRIES(64), .TAG_BITS(24)) dut (
    .CLK(clk), .RESET(rst_n), .Fetch_PC(fetch_pc), .STALL(stall),
    .Pred_Valid(pred_valid), .Pred_PC(pred_pc), .Pred_Taken(pred_taken),
    .Pred_Target(pred_target), .Update_Valid(upd_valid), .Update_PC(upd_pc),
    .Update_Taken(upd_taken), .Update_Target(upd_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt);
    fetch_pc   = fpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
    @(posedge clk);
    #1;
  endtask

  task automatic pred(input string tag, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt);
    chk({tag, ".valid"},  {31'd0, pred_valid}, 32'd1);
    chk({tag, ".pc"},     pred_pc, pc);
    chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, tk});
    chk({tag, ".target"}, pred_target, tgt);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, ".valid"},  {31'd0, pred_valid}, 32'd0);
    chk({tag, ".pc"},     pred_pc, 32'd0);
    chk({tag, ".taken"},  {31'd0, pred_taken}, 32'd0);
    chk({tag, ".target"}, pred_target, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; fetch_pc = P;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    #3;
    zero_outs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step(P, 0, 0, 0, 0);        pred("first_lookup", P, 0, 0);
    step(P, 1, P, 1, T1);       pred("alloc_rbw", P, 0, 0);
    step(P, 0, 0, 0, 0);        pred("hit_10", P, 1, T1);
    step(P, 1, P, 0, 0);        pred("nt1_sees10", P, 1, T1);
    step(P, 1, P, 0, 0);        pred("nt2_sees01", P, 0, T1);
    step(P, 1, P, 0, 0);        pred("nt3_sees00", P, 0, T1);
    step(P, 1, P, 1, T2);       pred("floor_hold", P, 0, T1);
    step(P, 1, P, 1, T2);       pred("up_sees01", P, 0, T2);
    step(P, 1, P, 1, T2);       pred("up_sees10", P, 1, T2);
    step(P, 1, P, 0, 0);        pred("up_sees11", P, 1, T2);
    step(P, 0, 0, 0, 0);        pred("ceil_hold", P, 1, T2);

    step(A, 0, 0, 0, 0);        pred("alias_miss", A, 0, 0);
    step(A, 1, A, 1, T1);       pred("alias_alloc", A, 0, 0);
    step(P, 0, 0, 0, 0);        pred("evicted_miss", P, 0, 0);
    step(A, 0, 0, 0, 0);        pred("alias_hit", A, 1, T1);

    step(Q, 1, Q, 1, T2);       pred("rbw_miss", Q, 0, 0);
    step(Q, 0, 0, 0, 0);        pred("rbw_hit", Q, 1, T2);

    stall = 1'b1;
    step(A, 1, Q, 0, 0);        pred("stall1", Q, 1, T2);
    step(A, 0, 0, 0, 0);        pred("stall2", Q, 1, T2);
    step(A, 0, 0, 0, 0);        pred("stall3", Q, 1, T2);
    stall = 1'b0;
    step(Q, 0, 0, 0, 0);        pred("stall_commit", Q, 0, T2);

    step(R, 1, R, 0, 0);        pred("nt_miss", R, 0, 0);
    step(R, 0, 0, 0, 0);        pred("nt_no_alloc", R, 0, 0);

    rst_n = 1'b0;
    #1 zero_outs("async_reset");
    stall = 1'b1;
    step(Q, 1, Q, 1, T1);
    zero_outs("reset_hold");
    rst_n = 1'b1;
    step(A, 0, 0, 0, 0);
    chk("stall_after_reset.valid", {31'd0, pred_valid}, 32'd0);
    stall = 1'b0;
    step(A, 0, 0, 0, 0);        pred("post_reset_a", A, 0, 0);
    step(Q, 0, 0, 0, 0);        pred("post_reset_q", Q, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
